// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo -- single-clock synchronous FIFO with registered read data,
// write-accept / read-valid strobes and programmable almost-full /
// almost-empty thresholds.
//
// Parameters
//   WIDTH   data word width in bits (>= 1)
//   DEPTH   number of storage entries (power of two, >= 2)
//   H_POS   almost-full threshold in entries  (L_POS < H_POS <= DEPTH)
//   L_POS   almost-empty threshold in entries (0 <= L_POS < H_POS)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   we       in   write request
//   din      in   write data, sampled with we
//   full     out  FIFO holds DEPTH entries
//   re       in   read request
//   dout     out  registered read data, holds when no read is accepted
//   empty    out  FIFO holds 0 entries
//   val      out  one-cycle strobe: dout carries the word of an accepted read
//   ack      out  one-cycle strobe: the previous cycle's write was accepted
//   p_full   out  almost full  (count >= H_POS)
//   p_empty  out  almost empty (count <= L_POS)
// ---------------------------------------------------------------------------
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int H_POS = 14,
    parameter int L_POS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             val,
    output logic             ack,
    output logic             p_full,
    output logic             p_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] H_POS_C = CW'(H_POS);
    localparam logic [CW-1:0] L_POS_C = CW'(L_POS);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             val_q,    val_d;
    logic             ack_q,    ack_d;

    logic wr_en;
    logic rd_en;

    // Status flags are decoded from the registered count only, so an
    // accepted operation shows up in the flags the cycle after its edge.
    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        p_full  = (count_q >= H_POS_C);
        p_empty = (count_q <= L_POS_C);
    end

    // A write while full is dropped even if a read is accepted in the same
    // cycle; a read while empty never bypasses a simultaneous write.
    assign wr_en = we & ~full;
    assign rd_en = re & ~empty;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        val_d    = rd_en;
        ack_d    = wr_en;

        // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 for free.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            val_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            val_q    <= val_d;
            ack_q    <= ack_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the count and pointers
    // already makes its old contents unreachable, and an unreset array can map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout = dout_q;
    assign val  = val_q;
    assign ack  = ack_q;

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo -- self-checking bench for fifo (default parameters).
// The stimulus process drives one request per cycle and updates a queue-based
// reference model: the model FIFO is a plain queue, and every word it hands
// out on an accepted read is pushed into an expected-data queue.  A separate
// monitor samples the DUT on the falling edge, compares flags and strobes
// against the model occupancy, and pops the expected-data queue whenever the
// DUT raises val.
// ---------------------------------------------------------------------------
module tb_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int H_POS = 14;
    localparam int L_POS = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             re;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             val;
    logic             ack;
    logic             p_full;
    logic             p_empty;

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .H_POS (H_POS),
        .L_POS (L_POS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .din     (din),
        .full    (full),
        .re      (re),
        .dout    (dout),
        .empty   (empty),
        .val     (val),
        .ack     (ack),
        .p_full  (p_full),
        .p_empty (p_empty)
    );

    always #5 clk = ~clk;

    // Reference model state
    int               mdl_q[$];   // words currently stored, oldest first
    int               exp_q[$];   // words the DUT should present with val
    logic             exp_ack;
    logic             exp_val;
    logic [WIDTH-1:0] exp_dout;   // value dout must hold

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus; starts and ends 1 time unit after a
    // rising edge.
    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
        int sz;
        bit w_acc;
        bit r_acc;
        int word;
        sz    = mdl_q.size();
        w_acc = w && (sz < DEPTH);
        r_acc = r && (sz > 0);
        we    = w;
        re    = r;
        din   = d;
        @(posedge clk);
        #1;
        if (r_acc) begin
            word     = mdl_q.pop_front();
            exp_q.push_back(word);
            exp_dout = WIDTH'(word);
        end
        if (w_acc) begin
            mdl_q.push_back(int'(d));
        end
        exp_ack = w_acc;
        exp_val = r_acc;
        we      = 1'b0;
        re      = 1'b0;
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        exp_ack  = 1'b0;
        exp_val  = 1'b0;
        exp_dout = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"},   32'(empty),   32'd1);
        check({tag, "_p_empty"}, 32'(p_empty), 32'd1);
        check({tag, "_full"},    32'(full),    32'd0);
        check({tag, "_p_full"},  32'(p_full),  32'd0);
        check({tag, "_dout"},    32'(dout),    32'd0);
        check({tag, "_val"},     32'(val),     32'd0);
        check({tag, "_ack"},     32'(ack),     32'd0);
    endtask

    // Monitor: compares every cycle on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            sz = mdl_q.size();
            check("ack",     32'(ack),     32'(exp_ack));
            check("val",     32'(val),     32'(exp_val));
            check("full",    32'(full),    32'(sz == DEPTH));
            check("empty",   32'(empty),   32'(sz == 0));
            check("p_full",  32'(p_full),  32'(sz >= H_POS));
            check("p_empty", 32'(p_empty), 32'(sz <= L_POS));
            check("dout_hold", 32'(dout),  32'(exp_dout));
            if (val) begin
                if (exp_q.size() == 0) begin
                    check("val_unexpected", 32'(val), 32'd0);
                end else begin
                    check("dout_order", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        re  = 1'b0;
        din = '0;
        model_reset();

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // Idle after reset.
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        check_reset_outputs("idle");

        // 16 back-to-back writes 0..15, then a dropped write of 0xAA.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, WIDTH'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 8'hAA);
        check("overflow_ack", 32'(ack), 32'd0);
        // Full write with a concurrent read still drops the write.
        cycle(1'b1, 1'b1, 8'hBB);
        check("overflow_rw_full", 32'(full), 32'd0);
        cycle(1'b1, 1'b0, 8'd16);   // refill to 16 with a known word

        // Drain: 16 reads, then an extra read on empty.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, '0);
        end
        check("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b1, '0);
        check("underflow_val", 32'(val), 32'd0);
        check("underflow_dout", 32'(dout), 32'd16);
        // Read while empty with a simultaneous write: no bypass.
        cycle(1'b1, 1'b1, 8'h5A);
        check("no_bypass_val", 32'(val), 32'd0);
        cycle(1'b0, 1'b1, '0);

        // Count 5, then 20 cycles of simultaneous read/write across the wrap.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, WIDTH'(8'h40 + i));
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, WIDTH'(8'h60 + i));
        end
        check("rw_count_p_empty", 32'(p_empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, '0);
        end
        check("rw_drained", 32'(empty), 32'd1);

        // Reset mid-burst with 8 entries stored.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, WIDTH'(8'hC0 + i));
        end
        #2 rst = 1'b0;
        model_reset();
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b1, 1'b0, 8'h77);
        cycle(1'b1, 1'b0, 8'h78);
        cycle(1'b0, 1'b1, '0);
        check("post_rst_data0", 32'(dout), 32'h77);
        cycle(1'b0, 1'b1, '0);
        check("post_rst_data1", 32'(dout), 32'h78);
        cycle(1'b0, 1'b1, '0);
        check("post_rst_empty_val", 32'(val), 32'd0);

        // Randomized traffic in phases biased toward filling and draining.
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            int rp;
            wp = (ph % 2 == 0) ? 80 : 30;
            rp = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                      WIDTH'($urandom));
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1'b0, 1'b1, '0);
        end
        cycle(1'b0, 1'b0, '0);

        @(negedge clk);
        #1 mon_en = 1'b0;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
